// File: rtl/morra_pkg.sv
// Shared types for the morra cinese (rock/paper/scissors) game engine.
package morra_pkg;

  typedef enum logic [1:0] {
    MV_NONE     = 2'b00,
    MV_ROCK     = 2'b01,
    MV_PAPER    = 2'b10,
    MV_SCISSORS = 2'b11
  } move_t;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_P1   = 2'b01,
    RES_P2   = 2'b10,
    RES_DRAW = 2'b11
  } res_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10
  } state_t;

  localparam int         CNT_W      = 5;
  localparam logic [4:0] MIN_ROUNDS = 5'd4;
  localparam logic [4:0] WIN_MARGIN = 5'd2;

  // True when move a defeats move b (both assumed non-NONE).
  function automatic logic beats(input move_t a, input move_t b);
    return ((a == MV_ROCK)     && (b == MV_SCISSORS)) ||
           ((a == MV_SCISSORS) && (b == MV_PAPER))    ||
           ((a == MV_PAPER)    && (b == MV_ROCK));
  endfunction

endpackage

// File: rtl/morra_round_judge.sv
// Combinational referee for a single round: decides winner/draw, or flags
// the round invalid (missing move, or last winner repeating its winning move).
module morra_round_judge
  import morra_pkg::*;
(
  input  move_t i_p1,
  input  move_t i_p2,
  input  res_t  i_last_win,
  input  move_t i_last_move,
  output res_t  o_result
);

  logic w_missing;
  logic w_repeat;

  assign w_missing = (i_p1 == MV_NONE) || (i_p2 == MV_NONE);
  assign w_repeat  = ((i_last_win == RES_P1) && (i_p1 == i_last_move)) ||
                     ((i_last_win == RES_P2) && (i_p2 == i_last_move));

  // Resolve the round outcome, invalid cases take precedence.
  always_comb begin
    o_result = RES_NONE;
    if (!w_missing && !w_repeat) begin
      if (i_p1 == i_p2)          o_result = RES_DRAW;
      else if (beats(i_p1, i_p2)) o_result = RES_P1;
      else                        o_result = RES_P2;
    end
  end

endmodule

// File: rtl/morra_cinese.sv
// Morra cinese game controller: round counting, win tallies, end-of-game
// detection and the IDLE/PLAY/OVER state machine. Outputs are registered.
module morra_cinese
  import morra_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] PRIMO,
  input  logic [1:0] SECONDO,
  input  logic       INIZIO,
  output logic [1:0] MANCHE,
  output logic [1:0] PARTITA
);

  state_t             r_state,   w_state_nxt;
  logic [CNT_W-1:0]   r_max,     w_max_nxt;
  logic [CNT_W-1:0]   r_played,  w_played_nxt;
  logic [CNT_W-1:0]   r_w1,      w_w1_nxt;
  logic [CNT_W-1:0]   r_w2,      w_w2_nxt;
  res_t               r_lastw,   w_lastw_nxt;
  move_t              r_lastmv,  w_lastmv_nxt;
  res_t               r_manche,  w_manche_nxt;
  res_t               r_partita, w_partita_nxt;

  move_t              w_p1;
  move_t              w_p2;
  res_t               w_round;
  logic [CNT_W-1:0]   w_played_inc;
  logic [CNT_W-1:0]   w_w1_inc;
  logic [CNT_W-1:0]   w_w2_inc;
  logic               w_margin;

  assign w_p1 = move_t'(PRIMO);
  assign w_p2 = move_t'(SECONDO);

  morra_round_judge u_judge (
    .i_p1        (w_p1),
    .i_p2        (w_p2),
    .i_last_win  (r_lastw),
    .i_last_move (r_lastmv),
    .o_result    (w_round)
  );

  // Tallies as they would stand if the current round is accepted.
  assign w_played_inc = r_played + 5'd1;
  assign w_w1_inc     = r_w1 + ((w_round == RES_P1) ? 5'd1 : 5'd0);
  assign w_w2_inc     = r_w2 + ((w_round == RES_P2) ? 5'd1 : 5'd0);
  assign w_margin     = (w_w1_inc >= w_w2_inc + WIN_MARGIN) ||
                        (w_w2_inc >= w_w1_inc + WIN_MARGIN);

  assign MANCHE  = r_manche;
  assign PARTITA = r_partita;

  // Next-state, counter and output decode; INIZIO overrides everything.
  always_comb begin
    w_state_nxt   = r_state;
    w_max_nxt     = r_max;
    w_played_nxt  = r_played;
    w_w1_nxt      = r_w1;
    w_w2_nxt      = r_w2;
    w_lastw_nxt   = r_lastw;
    w_lastmv_nxt  = r_lastmv;
    w_manche_nxt  = RES_NONE;
    w_partita_nxt = r_partita;

    if (INIZIO) begin
      w_state_nxt   = ST_PLAY;
      w_max_nxt     = MIN_ROUNDS + {1'b0, PRIMO, SECONDO};
      w_played_nxt  = '0;
      w_w1_nxt      = '0;
      w_w2_nxt      = '0;
      w_lastw_nxt   = RES_NONE;
      w_lastmv_nxt  = MV_NONE;
      w_partita_nxt = RES_NONE;
    end else begin
      case (r_state)
        ST_PLAY: begin
          w_partita_nxt = RES_NONE;
          if (w_round != RES_NONE) begin
            w_manche_nxt = w_round;
            w_played_nxt = w_played_inc;
            w_w1_nxt     = w_w1_inc;
            w_w2_nxt     = w_w2_inc;
            case (w_round)
              RES_P1: begin
                w_lastw_nxt  = RES_P1;
                w_lastmv_nxt = w_p1;
              end
              RES_P2: begin
                w_lastw_nxt  = RES_P2;
                w_lastmv_nxt = w_p2;
              end
              default: begin
                w_lastw_nxt  = RES_NONE;
                w_lastmv_nxt = MV_NONE;
              end
            endcase
            if ((w_played_inc >= MIN_ROUNDS) && w_margin) begin
              w_partita_nxt = (w_w1_inc > w_w2_inc) ? RES_P1 : RES_P2;
              w_state_nxt   = ST_OVER;
            end else if (w_played_inc == r_max) begin
              if (w_w1_inc > w_w2_inc)      w_partita_nxt = RES_P1;
              else if (w_w2_inc > w_w1_inc) w_partita_nxt = RES_P2;
              else                          w_partita_nxt = RES_DRAW;
              w_state_nxt = ST_OVER;
            end
          end
        end
        ST_OVER: w_state_nxt = ST_OVER;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, counters and registered outputs; reset returns to an idle board.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_max     <= MIN_ROUNDS;
      r_played  <= '0;
      r_w1      <= '0;
      r_w2      <= '0;
      r_lastw   <= RES_NONE;
      r_lastmv  <= MV_NONE;
      r_manche  <= RES_NONE;
      r_partita <= RES_NONE;
    end else begin
      r_state   <= w_state_nxt;
      r_max     <= w_max_nxt;
      r_played  <= w_played_nxt;
      r_w1      <= w_w1_nxt;
      r_w2      <= w_w2_nxt;
      r_lastw   <= w_lastw_nxt;
      r_lastmv  <= w_lastmv_nxt;
      r_manche  <= w_manche_nxt;
      r_partita <= w_partita_nxt;
    end
  end

endmodule

// File: tb/tb_morra_cinese.sv
// Bench for morra_cinese: directed game scenarios, a game-rules model checked
// every cycle, plus literal expectations at key points.
module tb_morra_cinese;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] PRIMO;
  logic [1:0] SECONDO;
  logic       INIZIO;
  logic [1:0] MANCHE;
  logic [1:0] PARTITA;

  int checks = 0;
  int errors = 0;

  // Game-rules model state (moves: 1 rock, 2 paper, 3 scissors).
  int m_mode   = 0;  // 0 idle, 1 playing, 2 finished
  int m_max    = 4;
  int m_played = 0;
  int m_w1     = 0;
  int m_w2     = 0;
  int m_lw     = 0;
  int m_lm     = 0;
  int e_manche = 0;
  int e_partita = 0;

  always #5 clk = ~clk;

  morra_cinese dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .PRIMO   (PRIMO),
    .SECONDO (SECONDO),
    .INIZIO  (INIZIO),
    .MANCHE  (MANCHE),
    .PARTITA (PARTITA)
  );

  task automatic chk(input string nm, input logic [1:0] got, input logic [1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b at %0t", nm, got, want, $time);
    end
  endtask

  // Model of the game rules, evaluated on the same edge as the DUT.
  always @(posedge clk or negedge rst_n) begin
    int a, b;
    if (!rst_n) begin
      m_mode = 0; m_max = 4; m_played = 0; m_w1 = 0; m_w2 = 0;
      m_lw = 0; m_lm = 0; e_manche = 0; e_partita = 0;
    end else begin
      a = int'(PRIMO);
      b = int'(SECONDO);
      if (INIZIO) begin
        m_mode = 1; m_max = 4 + a * 4 + b;
        m_played = 0; m_w1 = 0; m_w2 = 0; m_lw = 0; m_lm = 0;
        e_manche = 0; e_partita = 0;
      end else if (m_mode != 1) begin
        e_manche = 0;
      end else begin
        e_partita = 0;
        if (a == 0 || b == 0 || (m_lw == 1 && a == m_lm) || (m_lw == 2 && b == m_lm)) begin
          e_manche = 0;
        end else begin
          m_played++;
          if (a == b) begin
            e_manche = 3; m_lw = 0; m_lm = 0;
          end else if ((a - b + 3) % 3 == 1) begin
            e_manche = 1; m_w1++; m_lw = 1; m_lm = a;
          end else begin
            e_manche = 2; m_w2++; m_lw = 2; m_lm = b;
          end
          if (m_played >= 4 && (m_w1 - m_w2 >= 2 || m_w2 - m_w1 >= 2)) begin
            e_partita = (m_w1 > m_w2) ? 1 : 2; m_mode = 2;
          end else if (m_played == m_max) begin
            e_partita = (m_w1 > m_w2) ? 1 : (m_w2 > m_w1) ? 2 : 3; m_mode = 2;
          end
        end
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    chk("model_manche",  MANCHE,  e_manche[1:0]);
    chk("model_partita", PARTITA, e_partita[1:0]);
  end

  task automatic cyc(input logic [1:0] p, input logic [1:0] s, input logic ini);
    PRIMO = p; SECONDO = s; INIZIO = ini;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [1:0] m, input logic [1:0] g);
    chk({nm, "_manche"},  MANCHE,  m);
    chk({nm, "_partita"}, PARTITA, g);
  endtask

  initial begin
    rst_n = 1'b0; PRIMO = 2'b00; SECONDO = 2'b00; INIZIO = 1'b0;
    #12;
    lit("reset", 2'b00, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle ignores moves
    cyc(2'b01, 2'b11, 1'b0); lit("idle", 2'b00, 2'b00);

    // MAX=4, P1 sweeps four rounds
    cyc(2'b00, 2'b00, 1'b1); lit("start4", 2'b00, 2'b00);
    cyc(2'b01, 2'b11, 1'b0); lit("sweep_r1", 2'b01, 2'b00);
    cyc(2'b10, 2'b01, 1'b0); lit("sweep_r2", 2'b01, 2'b00);
    cyc(2'b11, 2'b10, 1'b0); lit("sweep_r3", 2'b01, 2'b00);
    cyc(2'b01, 2'b11, 1'b0); lit("sweep_r4", 2'b01, 2'b01);
    cyc(2'b01, 2'b11, 1'b0); lit("over_hold", 2'b00, 2'b01);

    // MAX=14, repeat-move and missing-move rejection
    cyc(2'b10, 2'b10, 1'b1); lit("start14", 2'b00, 2'b00);
    cyc(2'b01, 2'b10, 1'b0); lit("p2_paper", 2'b10, 2'b00);
    cyc(2'b11, 2'b10, 1'b0); lit("p2_repeat", 2'b00, 2'b00);
    cyc(2'b01, 2'b00, 1'b0); lit("missing", 2'b00, 2'b00);
    cyc(2'b01, 2'b11, 1'b0); lit("g14_r2", 2'b01, 2'b00);
    cyc(2'b10, 2'b01, 1'b0); lit("g14_r3", 2'b01, 2'b00);
    cyc(2'b11, 2'b10, 1'b0); lit("g14_r4", 2'b01, 2'b01);

    // MAX=4, four draws
    cyc(2'b00, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(2'b01, 2'b01, 1'b0); lit("draw", 2'b11, 2'b00);
    end
    cyc(2'b01, 2'b01, 1'b0); lit("draw_end", 2'b11, 2'b11);
    cyc(2'b01, 2'b11, 1'b0); lit("draw_hold", 2'b00, 2'b11);

    // Restart mid-game with MAX=5
    cyc(2'b00, 2'b00, 1'b1);
    cyc(2'b01, 2'b11, 1'b0); lit("mid_r1", 2'b01, 2'b00);
    cyc(2'b00, 2'b01, 1'b1); lit("restart5", 2'b00, 2'b00);
    for (int i = 0; i < 4; i++) cyc(2'b01, 2'b01, 1'b0);
    lit("max5_r4", 2'b11, 2'b00);
    cyc(2'b10, 2'b10, 1'b0); lit("max5_r5", 2'b11, 2'b11);

    // MAX=19 boundary, all draws
    cyc(2'b11, 2'b11, 1'b1);
    for (int i = 0; i < 18; i++) cyc(2'b11, 2'b11, 1'b0);
    lit("max19_r18", 2'b11, 2'b00);
    cyc(2'b11, 2'b11, 1'b0); lit("max19_r19", 2'b11, 2'b11);

    // Asynchronous reset mid-game
    cyc(2'b00, 2'b00, 1'b1);
    cyc(2'b01, 2'b11, 1'b0); lit("pre_rst", 2'b01, 2'b00);
    #2 rst_n = 1'b0;
    #1 lit("async_rst", 2'b00, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(2'b01, 2'b11, 1'b0); lit("post_rst1", 2'b00, 2'b00);
    cyc(2'b10, 2'b01, 1'b0); lit("post_rst2", 2'b00, 2'b00);

    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
